register_file_bank: RTL and testbench
=====================================

Name: register_file_bank

Overview:
- Parametrised multi-port architectural register file for the Y86 datapath.
- Replaces the per-register update cells with one bank of NREGS registers.
- Two combinational read ports (A, B) and two clocked write ports (E from execute, M from memory).
- Optional write-to-read bypass, plus a per-register busy scoreboard that flags read-after-write hazards to pipeline control.

Parameters:
- WIDTH, 64: data width of each register.
- NREGS, 15: number of architectural registers; legal addresses are 0..NREGS-1.
- ADDR_W, 4: width of every address port.
- NONE_ADDR, 4'hF: "no register" code; reads return 0, writes and busy-sets are ignored.
- BYPASS, 1: 1 means a read port returns data being written in the same cycle; 0 means a read returns the stored value only.
- RESET_VAL, 0: value loaded into every register on reset.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- srcA, input, ADDR_W: read address, port A.
- srcB, input, ADDR_W: read address, port B.
- valA, output, WIDTH: read data, port A.
- valB, output, WIDTH: read data, port B.
- dstE, input, ADDR_W: write address, port E.
- valE, input, WIDTH: write data, port E.
- weE, input, 1: write enable, port E.
- dstM, input, ADDR_W: write address, port M.
- valM, input, WIDTH: write data, port M.
- weM, input, 1: write enable, port M.
- set_addr, input, ADDR_W: register to mark busy, i.e. a pending producer issued.
- set_en, input, 1: busy-set enable.
- hazardA, output, 1: srcA is busy and its value is not yet available.
- hazardB, output, 1: srcB is busy and its value is not yet available.
- busy_vec, output, NREGS: current scoreboard bits; bit i corresponds to register i.

Behaviour:
- Reset:
  - reset low asynchronously forces every register to RESET_VAL and clears all busy bits, independent of clock.
  - While reset is low: writes and busy-sets are blocked; valA/valB show RESET_VAL for legal addresses (no bypass); hazardA/B = 0.
  - Release is sampled normally; the first write takes effect at the first rising edge with reset high.
- Write, at rising edge with reset high:
  - weE with a legal dstE stores valE; weM with a legal dstM stores valM.
  - A dstE or dstM of NONE_ADDR, or any address >= NREGS, means no write occurs.
  - If weE and weM target the same legal address, valM is stored (M priority, per popq %rsp semantics).
  - Writes to different addresses both complete in the same cycle.
- Read, combinational with zero latency:
  - srcX of NONE_ADDR or >= NREGS gives valX = 0.
  - BYPASS = 1: if the same cycle has a qualifying M write to srcX, valX = valM. Otherwise, if there is a qualifying E write to srcX, valX = valE. Otherwise valX is the stored value.
  - BYPASS = 0: valX is always the stored value; new data is visible the cycle after the edge.
- Scoreboard, at rising edge:
  - A qualifying write via E or M clears busy[dst].
  - set_en with a legal set_addr sets busy[set_addr].
  - If a set and a clear hit the same register in the same cycle, the set wins (a newer producer is pending).
  - Busy-set to an illegal address is ignored.
- Hazards:
  - hazardX = busy[srcX] AND NOT (BYPASS AND a qualifying write to srcX this cycle).
  - hazardX is 0 for illegal or NONE srcX.
  - With BYPASS = 0, hazardX stays 1 through the write cycle and drops the next cycle.
- No other state.
- Widths:
  - Data passes through unmodified.
  - Address comparisons use the full ADDR_W bits.
  - NREGS may be less than 2^ADDR_W; unused codes behave as NONE.

Test Plan:
- Reset low mid-run after writing reg 3 = 0x55: reg 3 reads RESET_VAL (0) immediately, without a clock edge, and busy_vec = 0.
- Write weE, dstE = 2, valE = 0x1111 and weM, dstM = 5, valM = 0x2222 in one cycle: next cycle srcA = 2 gives 0x1111 and srcB = 5 gives 0x2222.
- Drive weE/weM to dstE = dstM = 4 with valE = 0xAA and valM = 0xBB: stored value is 0xBB; with BYPASS = 1, srcA = 4 shows 0xBB in the write cycle itself.
- BYPASS = 0, write reg 7 = 0x99 while srcA = 7 (old value 0): valA = 0 in the write cycle and 0x99 the next cycle.
- Scoreboard sequence:
  - set_en, set_addr = 6 gives busy_vec[6] = 1 and srcB = 6 gives hazardB = 1.
  - Write to reg 6 with BYPASS = 1 gives hazardB = 0 in that cycle.
  - Simultaneous set and write to 6 leaves busy_vec[6] = 1.
- Illegal and NONE addresses: write dstE = 4'hF with valE = 0xDEAD, and set_addr = 4'hF; no register changes, busy_vec is unchanged, and srcA = 4'hF reads 0 with hazardA = 0.

Source files
------------

// File: rtl/register_file_bank.sv
// Y86 architectural register file: two combinational read ports, two clocked
// write ports (E, M), optional write-to-read bypass and a busy scoreboard.
module register_file_bank #(
  parameter int unsigned       WIDTH     = 64,
  parameter int unsigned       NREGS     = 15,
  parameter int unsigned       ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] NONE_ADDR = '1,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [WIDTH-1:0]  valA,
  output logic [WIDTH-1:0]  valB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [WIDTH-1:0]  valE,
  input  logic              weE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [WIDTH-1:0]  valM,
  input  logic              weM,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              set_en,
  output logic              hazardA,
  output logic              hazardB,
  output logic [NREGS-1:0]  busy_vec
);

  localparam logic [ADDR_W:0] NREGS_LIM = (ADDR_W+1)'(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             qual_e;
  logic             qual_m;
  logic             qual_set;

  // Unused codes above NREGS-1 behave exactly like NONE_ADDR.
  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    return (a != NONE_ADDR) && ({1'b0, a} < NREGS_LIM);
  endfunction

  // Qualifiers include reset so that nothing bypasses while the bank is held.
  assign qual_e   = reset && weE    && is_legal(dstE);
  assign qual_m   = reset && weM    && is_legal(dstM);
  assign qual_set = reset && set_en && is_legal(set_addr);

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] src);
    logic [WIDTH-1:0] r;
    r = '0;
    if (is_legal(src)) begin
      if (BYPASS && qual_m && (dstM == src))
        r = valM;
      else if (BYPASS && qual_e && (dstE == src))
        r = valE;
      else
        r = regs[src];
    end
    return r;
  endfunction

  function automatic logic hazard_port(input logic [ADDR_W-1:0] src);
    logic h;
    logic hit;
    h   = 1'b0;
    hit = (qual_m && (dstM == src)) || (qual_e && (dstE == src));
    if (is_legal(src))
      h = busy_q[src] && !(BYPASS && hit);
    return h;
  endfunction

  always_comb begin
    valA    = read_port(srcA);
    valB    = read_port(srcB);
    hazardA = hazard_port(srcA);
    hazardB = hazard_port(srcB);
  end

  // M is written after E so it wins when both target the same register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= RESET_VAL;
    end else begin
      if (qual_e) regs[dstE] <= valE;
      if (qual_m) regs[dstM] <= valM;
    end
  end

  // Set is applied last: a newly issued producer outranks a completing one.
  always_comb begin
    busy_d = busy_q;
    if (qual_e)   busy_d[dstE]     = 1'b0;
    if (qual_m)   busy_d[dstM]     = 1'b0;
    if (qual_set) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_bank.sv
// Bench for register_file_bank: one bypassing and one non-bypassing instance
// share stimulus and are compared against an array-based reference model.
module tb_register_file_bank;

  logic        clock;
  logic        rst_n;
  logic [3:0]  srcA, srcB, dstE, dstM, set_addr;
  logic [63:0] valE, valM;
  logic        weE, weM, set_en;

  logic [63:0] valA1, valB1, valA0, valB0;
  logic        hazA1, hazB1, hazA0, hazB0;
  logic [14:0] busy1, busy0;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [15];
  logic [14:0] m_busy;

  register_file_bank #(.BYPASS(1'b1)) dut (
    .clock(clock), .reset(rst_n), .srcA(srcA), .srcB(srcB),
    .valA(valA1), .valB(valB1), .dstE(dstE), .valE(valE), .weE(weE),
    .dstM(dstM), .valM(valM), .weM(weM), .set_addr(set_addr), .set_en(set_en),
    .hazardA(hazA1), .hazardB(hazB1), .busy_vec(busy1)
  );

  register_file_bank #(.BYPASS(1'b0)) dut0 (
    .clock(clock), .reset(rst_n), .srcA(srcA), .srcB(srcB),
    .valA(valA0), .valB(valB0), .dstE(dstE), .valE(valE), .weE(weE),
    .dstM(dstM), .valM(valM), .weM(weM), .set_addr(set_addr), .set_en(set_en),
    .hazardA(hazA0), .hazardB(hazB0), .busy_vec(busy0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_val(input logic [3:0] src, input bit byp);
    if (src >= 4'd15) return 64'd0;
    if (rst_n && byp) begin
      if (weM && dstM == src) return valM;
      if (weE && dstE == src) return valE;
    end
    return m_regs[src];
  endfunction

  function automatic logic exp_haz(input logic [3:0] src, input bit byp);
    logic written;
    if (src >= 4'd15) return 1'b0;
    written = rst_n && ((weM && dstM == src) || (weE && dstE == src));
    return m_busy[src] && !(byp && written);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_busy = '0;
  endtask

  task automatic model_clock();
    if (rst_n) begin
      if (weE && dstE < 4'd15) m_regs[dstE] = valE;
      if (weM && dstM < 4'd15) m_regs[dstM] = valM;
      if (weE && dstE < 4'd15) m_busy[dstE] = 1'b0;
      if (weM && dstM < 4'd15) m_busy[dstM] = 1'b0;
      if (set_en && set_addr < 4'd15) m_busy[set_addr] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " valA/byp"},  valA1, exp_val(srcA, 1'b1));
    chk({tag, " valB/byp"},  valB1, exp_val(srcB, 1'b1));
    chk({tag, " valA/nob"},  valA0, exp_val(srcA, 1'b0));
    chk({tag, " valB/nob"},  valB0, exp_val(srcB, 1'b0));
    chk({tag, " hazA/byp"},  64'(hazA1), 64'(exp_haz(srcA, 1'b1)));
    chk({tag, " hazB/byp"},  64'(hazB1), 64'(exp_haz(srcB, 1'b1)));
    chk({tag, " hazA/nob"},  64'(hazA0), 64'(exp_haz(srcA, 1'b0)));
    chk({tag, " hazB/nob"},  64'(hazB0), 64'(exp_haz(srcB, 1'b0)));
    chk({tag, " busy/byp"},  64'(busy1), 64'(m_busy));
    chk({tag, " busy/nob"},  64'(busy0), 64'(m_busy));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc(input string tag);
    #1 check_all(tag);
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic idle();
    weE = 1'b0; weM = 1'b0; set_en = 1'b0;
    dstE = 4'd0; dstM = 4'd0; set_addr = 4'd0;
    valE = 64'd0; valM = 64'd0;
    srcA = 4'd0; srcB = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    cyc("reset");
    rst_n = 1'b1;

    // Two writes to different registers in one cycle
    idle(); weE = 1'b1; dstE = 4'd2; valE = 64'h1111;
    weM = 1'b1; dstM = 4'd5; valM = 64'h2222;
    cyc("wr2_5");
    idle(); srcA = 4'd2; srcB = 4'd5;
    #1 chk("rd2", valA1, 64'h1111); chk("rd5", valB1, 64'h2222);
    cyc("rd2_5");

    // E and M to the same register: M wins
    idle(); weE = 1'b1; dstE = 4'd4; valE = 64'hAA;
    weM = 1'b1; dstM = 4'd4; valM = 64'hBB; srcA = 4'd4;
    #1 chk("same_byp", valA1, 64'hBB); chk("same_nob", valA0, 64'd0);
    cyc("same_wr");
    idle(); srcA = 4'd4;
    #1 chk("same_store", valA1, 64'hBB); chk("same_store0", valA0, 64'hBB);
    cyc("same_rd");

    // Non-bypass visibility and hazard timing on reg 7
    idle(); set_en = 1'b1; set_addr = 4'd7;
    cyc("set7");
    idle(); weE = 1'b1; dstE = 4'd7; valE = 64'h99; srcA = 4'd7;
    #1 chk("nob_wrcyc", valA0, 64'd0); chk("byp_wrcyc", valA1, 64'h99);
    chk("nob_haz_wrcyc", 64'(hazA0), 64'd1); chk("byp_haz_wrcyc", 64'(hazA1), 64'd0);
    cyc("wr7");
    idle(); srcA = 4'd7;
    #1 chk("nob_next", valA0, 64'h99); chk("nob_haz_next", 64'(hazA0), 64'd0);
    cyc("rd7");

    // Scoreboard on reg 6
    idle(); set_en = 1'b1; set_addr = 4'd6;
    cyc("set6");
    idle(); srcB = 4'd6;
    #1 chk("busy6", 64'(busy1[6]), 64'd1); chk("hazB6", 64'(hazB1), 64'd1);
    cyc("haz6");
    idle(); weE = 1'b1; dstE = 4'd6; valE = 64'h66; srcB = 4'd6;
    #1 chk("hazB6_byp_wr", 64'(hazB1), 64'd0); chk("hazB6_nob_wr", 64'(hazB0), 64'd1);
    cyc("wr6");
    idle(); set_en = 1'b1; set_addr = 4'd6; weM = 1'b1; dstM = 4'd6; valM = 64'h67;
    cyc("set_wr6");
    idle(); srcB = 4'd6;
    #1 chk("set_wins", 64'(busy1[6]), 64'd1); chk("set_wins_haz", 64'(hazB1), 64'd1);
    cyc("after_set_wr6");

    // NONE / illegal addresses
    idle(); weE = 1'b1; dstE = 4'hF; valE = 64'hDEAD;
    set_en = 1'b1; set_addr = 4'hF; srcA = 4'hF;
    #1 chk("none_rd", valA1, 64'd0); chk("none_haz", 64'(hazA1), 64'd0);
    cyc("none_wr");
    #1 chk("none_busy", 64'(busy1), 64'h0040);
    for (int i = 0; i < 16; i++) begin
      idle(); srcA = 4'(i); srcB = 4'(15 - i);
      cyc("sweep");
    end

    // Asynchronous reset mid-run
    idle(); weE = 1'b1; dstE = 4'd3; valE = 64'h55; set_en = 1'b1; set_addr = 4'd3;
    cyc("wr3");
    idle(); srcA = 4'd3;
    #1 chk("pre_rst3", valA1, 64'h55);
    #2 rst_n = 1'b0;
    #1 chk("arst_val", valA1, 64'd0); chk("arst_busy", 64'(busy1), 64'd0);
    model_reset();
    @(negedge clock);
    idle(); weE = 1'b1; dstE = 4'd3; valE = 64'h77; weM = 1'b1; dstM = 4'd8;
    valM = 64'h88; set_en = 1'b1; set_addr = 4'd9; srcA = 4'd3; srcB = 4'd8;
    cyc("in_rst1");
    cyc("in_rst2");
    idle(); rst_n = 1'b1; srcA = 4'd3; srcB = 4'd8;
    #1 chk("rel_rd3", valA1, 64'd0); chk("rel_busy", 64'(busy1), 64'd0);
    cyc("release");

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      weE = 1'($urandom); weM = 1'($urandom); set_en = 1'($urandom);
      dstE = 4'($urandom_range(0, 15)); dstM = 4'($urandom_range(0, 15));
      set_addr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) dstM = dstE;
      valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
      srcA = 4'($urandom_range(0, 15)); srcB = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) srcA = dstE;
      if ($urandom_range(0, 2) == 0) srcB = dstM;
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
